// File: rtl/sid_filter_sched_pkg.sv
// Shared types and constants for the SID filter sample scheduler.
package sid_filter_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_START  = 2'd2,
        ST_RUN    = 2'd3
    } sched_state_e;

    // Filter register map (SID offsets)
    localparam logic [4:0] ADDR_FC_LO    = 5'h15;
    localparam logic [4:0] ADDR_FC_HI    = 5'h16;
    localparam logic [4:0] ADDR_RES_FILT = 5'h17;
    localparam logic [4:0] ADDR_MODE_VOL = 5'h18;

    localparam int unsigned PASS_LEN_DEFAULT = 11;

endpackage

// File: rtl/sid_filter_sched_if.sv
// Register bus, live sample inputs and filter-side outputs of the scheduler.
interface sid_filter_sched_if;
    logic        ce_1m;
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  data;
    logic [11:0] voice1_in;
    logic [11:0] voice2_in;
    logic [11:0] voice3_in;
    logic [11:0] ext_in;
    logic        ovr_clr;

    logic [10:0] Fc;
    logic [7:0]  Res_Filt;
    logic [7:0]  Mode_Vol;
    logic [11:0] voice1;
    logic [11:0] voice2;
    logic [11:0] voice3;
    logic [11:0] ext_o;
    logic        input_valid;
    logic        busy;
    logic [7:0]  overrun_cnt;

    modport master (
        output ce_1m, we, addr, data, voice1_in, voice2_in, voice3_in, ext_in, ovr_clr,
        input  Fc, Res_Filt, Mode_Vol, voice1, voice2, voice3, ext_o,
               input_valid, busy, overrun_cnt
    );

    modport slave (
        input  ce_1m, we, addr, data, voice1_in, voice2_in, voice3_in, ext_in, ovr_clr,
        output Fc, Res_Filt, Mode_Vol, voice1, voice2, voice3, ext_o,
               input_valid, busy, overrun_cnt
    );
endinterface

// File: rtl/sid_tick_div.sv
// Divides the chip-rate enable down to the filter sample tick (one tick per DIV ce_1m).
module sid_tick_div #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce_1m_i,
    output logic tick_o
);
    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tick_q, tick_d;

    // Next count and tick: tick fires on the ce_1m that wraps the counter
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (ce_1m_i) begin
            tick_d = (cnt_q == LAST);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 8'd1;
        end
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/sid_filter_sched.sv
// Filter sample scheduler: shadows filter registers, commits them with the live
// samples on each sample tick and drives one filter pass, counting dropped ticks.
module sid_filter_sched
    import sid_filter_sched_pkg::*;
#(
    parameter int unsigned DIV      = 1,
    parameter int unsigned PASS_LEN = PASS_LEN_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    sid_filter_sched_if.slave bus
);
    sched_state_e state_q, state_d;
    logic [3:0]   pass_cnt_q, pass_cnt_d;
    logic [7:0]   ovr_q, ovr_d;
    logic         tick;
    logic         commit;
    logic         drop;

    logic [7:0]   sh15_q, sh16_q, sh17_q, sh18_q;
    logic [10:0]  fc_q;
    logic [7:0]   res_q, mode_q;
    logic [11:0]  v1_q, v2_q, v3_q, ext_q;

    sid_tick_div #(.DIV(DIV)) u_div (
        .clk     (clk),
        .rst     (rst),
        .ce_1m_i (bus.ce_1m),
        .tick_o  (tick)
    );

    // Shadow register writes; a write during COMMIT lands here only, so the
    // commit below still sees the previous value
    always_ff @(posedge clk) begin
        if (rst) begin
            sh15_q <= '0;
            sh16_q <= '0;
            sh17_q <= '0;
            sh18_q <= '0;
        end else if (bus.we) begin
            case (bus.addr)
                ADDR_FC_LO:    sh15_q <= bus.data;
                ADDR_FC_HI:    sh16_q <= bus.data;
                ADDR_RES_FILT: sh17_q <= bus.data;
                ADDR_MODE_VOL: sh18_q <= bus.data;
                default: ;
            endcase
        end
    end

    // Next state, pass counter and commit strobe
    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                pass_cnt_d = 4'(PASS_LEN - 1);
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (pass_cnt_q == '0) state_d = ST_IDLE;
                else                  pass_cnt_d = pass_cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Overrun counter: ticks arriving while busy are dropped; clear has priority
    always_comb begin
        drop  = tick && (state_q != ST_IDLE);
        ovr_d = ovr_q;
        if (bus.ovr_clr)               ovr_d = '0;
        else if (drop && ovr_q != '1)  ovr_d = ovr_q + 8'd1;
    end

    // FSM, pass counter and overrun registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pass_cnt_q <= '0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    // Committed filter registers and voice holds, loaded only in COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q   <= '0;
            res_q  <= '0;
            mode_q <= '0;
            v1_q   <= '0;
            v2_q   <= '0;
            v3_q   <= '0;
            ext_q  <= '0;
        end else if (commit) begin
            fc_q   <= {sh16_q, sh15_q[2:0]};
            res_q  <= sh17_q;
            mode_q <= sh18_q;
            v1_q   <= bus.voice1_in;
            v2_q   <= bus.voice2_in;
            v3_q   <= bus.voice3_in;
            ext_q  <= bus.ext_in;
        end
    end

    assign bus.Fc          = fc_q;
    assign bus.Res_Filt    = res_q;
    assign bus.Mode_Vol    = mode_q;
    assign bus.voice1      = v1_q;
    assign bus.voice2      = v2_q;
    assign bus.voice3      = v3_q;
    assign bus.ext_o       = ext_q;
    assign bus.input_valid = (state_q == ST_START);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.overrun_cnt = ovr_q;

endmodule
